mips_cpu_alu_issue: RTL and testbench

Issue/sequencing block that sits in front of the CPU ALU: it accepts one MIPS instruction per handshake, reads rs/rt from the register file, decodes the ALU-class and BEQ/BNE instructions into a 4-bit ALU op with operands, waits for the ALU's registered result, then emits one writeback/branch response. It is the initiator to the ALU's responder and owns all instruction-to-op translation.

---
 rtl/mips_cpu_pkg.sv | 71 +++++++
 rtl/mips_cpu_alu_decode.sv | 66 ++++++
 rtl/mips_cpu_alu_issue.sv | 132 +++++++++++++
 tb/tb_mips_cpu_alu_issue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared encodings for the CPU ALU issue slice: ALU ops, MIPS opcode/funct
// constants, issue FSM states and decode side-band enums.
package mips_cpu_pkg;

  typedef enum logic [3:0] {
    ALU_AND    = 4'd0,
    ALU_OR     = 4'd1,
    ALU_ADD    = 4'd2,
    ALU_SUB    = 4'd3,
    ALU_SLT    = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SLL    = 4'd6,
    ALU_SRL    = 4'd7,
    ALU_SRA    = 4'd8,
    ALU_SLLV   = 4'd9,
    ALU_SRLV   = 4'd10,
    ALU_SRAV   = 4'd11,
    ALU_LUI    = 4'd12,
    ALU_SLTU   = 4'd13,
    ALU_PASS_A = 4'd14
  } alu_op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    B_RT   = 2'd0,
    B_SEXT = 2'd1,
    B_ZEXT = 2'd2
  } b_sel_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2
  } br_kind_e;

  function automatic logic [31:0] ext_imm(input b_sel_e sel, input logic [15:0] imm);
    if (sel == B_SEXT) ext_imm = {{16{imm[15]}}, imm};
    else               ext_imm = {16'd0, imm};
  endfunction

endpackage

// File: rtl/mips_cpu_alu_decode.sv
// Combinational MIPS instruction -> ALU op translation. Produces a zero
// destination for branches and unsupported encodings so no write is implied.
module mips_cpu_alu_decode
  import mips_cpu_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [20:0] instr_lo,
  output alu_op_e     op,
  output b_sel_e      b_sel,
  output logic [4:0]  sa,
  output logic [4:0]  dest,
  output br_kind_e    br_kind,
  output logic        illegal
);

  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] shamt;
  logic [5:0] funct;

  assign rt    = instr_lo[20:16];
  assign rd    = instr_lo[15:11];
  assign shamt = instr_lo[10:6];
  assign funct = instr_lo[5:0];

  always_comb begin
    op      = ALU_PASS_A;
    b_sel   = B_RT;
    sa      = 5'd0;
    dest    = 5'd0;
    br_kind = BR_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        dest = rd;
        case (funct)
          FN_ADDU: op = ALU_ADD;
          FN_SUBU: op = ALU_SUB;
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_XOR:  op = ALU_XOR;
          FN_SLT:  op = ALU_SLT;
          FN_SLTU: op = ALU_SLTU;
          FN_SLL:  begin op = ALU_SLL; sa = shamt; end
          FN_SRL:  begin op = ALU_SRL; sa = shamt; end
          FN_SRA:  begin op = ALU_SRA; sa = shamt; end
          FN_SLLV: op = ALU_SLLV;
          FN_SRLV: op = ALU_SRLV;
          FN_SRAV: op = ALU_SRAV;
          default: begin illegal = 1'b1; dest = 5'd0; end
        endcase
      end
      OPC_ADDIU: begin op = ALU_ADD;  b_sel = B_SEXT; dest = rt; end
      OPC_SLTI:  begin op = ALU_SLT;  b_sel = B_SEXT; dest = rt; end
      OPC_SLTIU: begin op = ALU_SLTU; b_sel = B_SEXT; dest = rt; end
      OPC_ANDI:  begin op = ALU_AND;  b_sel = B_ZEXT; dest = rt; end
      OPC_ORI:   begin op = ALU_OR;   b_sel = B_ZEXT; dest = rt; end
      OPC_XORI:  begin op = ALU_XOR;  b_sel = B_ZEXT; dest = rt; end
      OPC_LUI:   begin op = ALU_LUI;  b_sel = B_ZEXT; dest = rt; end
      OPC_BEQ:   begin op = ALU_SUB;  br_kind = BR_EQ; end
      OPC_BNE:   begin op = ALU_SUB;  br_kind = BR_NE; end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_cpu_alu_issue.sv
// Issue sequencer in front of the ALU: accepts one instruction, drives the
// ALU for one cycle, then emits a single-cycle writeback/branch response.
module mips_cpu_alu_issue
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [4:0]  rf_rs_addr,
  output logic [4:0]  rf_rt_addr,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_sa,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        res_valid,
  output logic        res_we,
  output logic [4:0]  res_addr,
  output logic [31:0] res_data,
  output logic        res_branch,
  output logic        res_taken,
  output logic        res_illegal,
  output state_e      dbg_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid
  // and instr_ready are both high; instr_ready is high only in ST_IDLE.

  alu_op_e    dec_op;
  b_sel_e     dec_b_sel;
  logic [4:0] dec_sa;
  logic [4:0] dec_dest;
  br_kind_e   dec_br;
  logic       dec_illegal;

  state_e     state_q,   state_d;
  alu_op_e    op_q,      op_d;
  logic [31:0] a_q,      a_d;
  logic [31:0] b_q,      b_d;
  logic [4:0] sa_q,      sa_d;
  logic [4:0] dest_q,    dest_d;
  br_kind_e   br_q,      br_d;
  logic       illegal_q, illegal_d;

  assign rf_rs_addr = instr[25:21];
  assign rf_rt_addr = instr[20:16];

  mips_cpu_alu_decode u_decode (
    .opcode   (instr[31:26]),
    .instr_lo (instr[20:0]),
    .op       (dec_op),
    .b_sel    (dec_b_sel),
    .sa       (dec_sa),
    .dest     (dec_dest),
    .br_kind  (dec_br),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    sa_d      = sa_q;
    dest_d    = dest_q;
    br_d      = br_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          state_d   = ST_EXEC;
          op_d      = dec_op;
          a_d       = rf_rs_data;
          b_d       = (dec_b_sel == B_RT) ? rf_rt_data : ext_imm(dec_b_sel, instr[15:0]);
          sa_d      = dec_sa;
          dest_d    = dec_dest;
          br_d      = dec_br;
          illegal_d = dec_illegal;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= ALU_PASS_A;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      sa_q      <= 5'd0;
      dest_q    <= 5'd0;
      br_q      <= BR_NONE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sa_q      <= sa_d;
      dest_q    <= dest_d;
      br_q      <= br_d;
      illegal_q <= illegal_d;
    end
  end

  // The ALU sees an idle PASS-A of zero except during the single EXEC cycle.
  assign alu_op = (state_q == ST_EXEC) ? op_q : ALU_PASS_A;
  assign alu_a  = (state_q == ST_EXEC) ? a_q  : 32'd0;
  assign alu_b  = (state_q == ST_EXEC) ? b_q  : 32'd0;
  assign alu_sa = (state_q == ST_EXEC) ? sa_q : 5'd0;

  assign instr_ready = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_RESP);
  // Decode zeroes dest for branches and illegal encodings, so dest alone gates the write.
  assign res_we      = (dest_q != 5'd0);
  assign res_addr    = dest_q;
  assign res_data    = alu_result;
  assign res_branch  = (br_q != BR_NONE);
  assign res_taken   = (state_q == ST_RESP) &&
                       (((br_q == BR_EQ) && alu_zero) || ((br_q == BR_NE) && !alu_zero));
  assign res_illegal = illegal_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mips_cpu_alu_issue.sv
// Directed bench for mips_cpu_alu_issue with a register-file array and a
// registered ALU model attached; expected responses are hand-computed.
module tb_mips_cpu_alu_issue;
  import mips_cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rf_rs_addr;
  logic [4:0]  rf_rt_addr;
  logic [31:0] rf_rs_data;
  logic [31:0] rf_rt_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_sa;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        res_valid;
  logic        res_we;
  logic [4:0]  res_addr;
  logic [31:0] res_data;
  logic        res_branch;
  logic        res_taken;
  logic        res_illegal;
  state_e      dbg_state;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [31:0] regs [32];

  mips_cpu_alu_issue dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_rs_addr  (rf_rs_addr),
    .rf_rt_addr  (rf_rt_addr),
    .rf_rs_data  (rf_rs_data),
    .rf_rt_data  (rf_rt_data),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sa      (alu_sa),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .res_valid   (res_valid),
    .res_we      (res_we),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .res_branch  (res_branch),
    .res_taken   (res_taken),
    .res_illegal (res_illegal),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rs_data = regs[rf_rs_addr];
  assign rf_rt_data = regs[rf_rt_addr];

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sa);
    case (op)
      4'd0:    alu_model = a & b;
      4'd1:    alu_model = a | b;
      4'd2:    alu_model = a + b;
      4'd3:    alu_model = a - b;
      4'd4:    alu_model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:    alu_model = a ^ b;
      4'd6:    alu_model = b << sa;
      4'd7:    alu_model = b >> sa;
      4'd8:    alu_model = $signed(b) >>> sa;
      4'd9:    alu_model = b << a[4:0];
      4'd10:   alu_model = b >> a[4:0];
      4'd11:   alu_model = $signed(b) >>> a[4:0];
      4'd12:   alu_model = {b[15:0], 16'd0};
      4'd13:   alu_model = (a < b) ? 32'd1 : 32'd0;
      4'd14:   alu_model = a;
      default: alu_model = 32'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) alu_result <= 32'd0;
    else       alu_result <= alu_model(alu_op, alu_a, alu_b, alu_sa);
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver: called at a negedge with the DUT idle; returns at a negedge
  task automatic run_instr(input string name, input logic [31:0] word,
                           input logic [3:0] e_op, input logic [31:0] e_a,
                           input logic [31:0] e_b, input logic [4:0] e_sa,
                           input logic e_we, input logic [4:0] e_addr,
                           input logic [31:0] e_data, input logic e_br,
                           input logic e_taken, input logic e_ill);
    instr = word;
    instr_valid = 1'b1;
    #1;
    check({name, ".rs_addr"}, 32'(rf_rs_addr), 32'(word[25:21]));
    check({name, ".rt_addr"}, 32'(rf_rt_addr), 32'(word[20:16]));
    check({name, ".ready"}, 32'(instr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = ~word;
    #1;
    check({name, ".op"}, 32'(alu_op), 32'(e_op));
    check({name, ".a"}, alu_a, e_a);
    check({name, ".b"}, alu_b, e_b);
    check({name, ".sa"}, 32'(alu_sa), 32'(e_sa));
    check({name, ".exec_valid"}, 32'(res_valid), 32'd0);
    check({name, ".exec_ready"}, 32'(instr_ready), 32'd0);
    @(negedge clk);
    check({name, ".valid"}, 32'(res_valid), 32'd1);
    check({name, ".we"}, 32'(res_we), 32'(e_we));
    check({name, ".addr"}, 32'(res_addr), 32'(e_addr));
    check({name, ".data"}, res_data, e_data);
    check({name, ".branch"}, 32'(res_branch), 32'(e_br));
    check({name, ".taken"}, 32'(res_taken), 32'(e_taken));
    check({name, ".illegal"}, 32'(res_illegal), 32'(e_ill));
    check({name, ".resp_op"}, 32'(alu_op), 32'd14);
    @(negedge clk);
    check({name, ".after_valid"}, 32'(res_valid), 32'd0);
    check({name, ".after_ready"}, 32'(instr_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    check("rst.ready", 32'(instr_ready), 32'd1);
    check("rst.valid", 32'(res_valid), 32'd0);
    check("rst.we", 32'(res_we), 32'd0);
    check("rst.branch", 32'(res_branch), 32'd0);
    check("rst.taken", 32'(res_taken), 32'd0);
    check("rst.illegal", 32'(res_illegal), 32'd0);
    check("rst.addr", 32'(res_addr), 32'd0);
    check("rst.data", res_data, 32'd0);
    check("rst.op", 32'(alu_op), 32'd14);
    check("rst.a", alu_a, 32'd0);
    check("rst.b", alu_b, 32'd0);
    check("rst.sa", 32'(alu_sa), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // ADDU $3,$1,$2
    regs[1] = 32'd5; regs[2] = 32'd7;
    run_instr("addu", 32'h00221821, 4'd2, 32'd5, 32'd7, 5'd0, 1'b1, 5'd3, 32'd12, 1'b0, 1'b0, 1'b0);
    // SRAV $4,$2,$1
    regs[1] = 32'h00000024; regs[2] = 32'h80000000;
    run_instr("srav", 32'h00222007, 4'd11, 32'h24, 32'h80000000, 5'd0, 1'b1, 5'd4, 32'hF8000000, 1'b0, 1'b0, 1'b0);
    // ORI $5,$0,0x8001 and ADDIU $6,$0,0x8001
    run_instr("ori", 32'h34058001, 4'd1, 32'd0, 32'h00008001, 5'd0, 1'b1, 5'd5, 32'h00008001, 1'b0, 1'b0, 1'b0);
    run_instr("addiu", 32'h24068001, 4'd2, 32'd0, 32'hFFFF8001, 5'd0, 1'b1, 5'd6, 32'hFFFF8001, 1'b0, 1'b0, 1'b0);
    // BEQ / BNE with rs == rt == 9
    regs[1] = 32'd9; regs[2] = 32'd9;
    run_instr("beq", 32'h10220010, 4'd3, 32'd9, 32'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    run_instr("bne", 32'h14220010, 4'd3, 32'd9, 32'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    // BNE with unequal operands is taken
    regs[2] = 32'd4;
    run_instr("bne_ne", 32'h14220010, 4'd3, 32'd9, 32'd4, 5'd0, 1'b0, 5'd0, 32'd5, 1'b1, 1'b1, 1'b0);
    // ADDU into $0
    regs[1] = 32'd5; regs[2] = 32'd7;
    run_instr("addu_r0", 32'h00220021, 4'd2, 32'd5, 32'd7, 5'd0, 1'b0, 5'd0, 32'd12, 1'b0, 1'b0, 1'b0);
    // opcode 0x3F is unsupported
    run_instr("illegal", 32'hFC000000, 4'd14, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    // SLTIU $7,$1,0xFFFF: 5 < 0xFFFFFFFF unsigned
    run_instr("sltiu", 32'h2C27FFFF, 4'd13, 32'd5, 32'hFFFFFFFF, 5'd0, 1'b1, 5'd7, 32'd1, 1'b0, 1'b0, 1'b0);
    // SLTI $7,$1,0xFFFF: 5 < -1 signed is false
    run_instr("slti", 32'h2827FFFF, 4'd4, 32'd5, 32'hFFFFFFFF, 5'd0, 1'b1, 5'd7, 32'd0, 1'b0, 1'b0, 1'b0);
    // LUI $8,0x1234
    run_instr("lui", 32'h3C081234, 4'd12, 32'd0, 32'h00001234, 5'd0, 1'b1, 5'd8, 32'h12340000, 1'b0, 1'b0, 1'b0);
    // SLL $9,$2,3
    run_instr("sll", 32'h000248C0, 4'd6, 32'd0, 32'd7, 5'd3, 1'b1, 5'd9, 32'd56, 1'b0, 1'b0, 1'b0);
    // SUBU $10,$1,$2: 5 - 7
    run_instr("subu", 32'h00225023, 4'd3, 32'd5, 32'd7, 5'd0, 1'b1, 5'd10, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);

    // reset while in EXEC drops the instruction
    instr = 32'h00221821;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check("rstx.exec_op", 32'(alu_op), 32'd2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rstx.valid", 32'(res_valid), 32'd0);
    check("rstx.ready", 32'(instr_ready), 32'd1);
    check("rstx.we", 32'(res_we), 32'd0);
    @(negedge clk);
    check("rstx.valid2", 32'(res_valid), 32'd0);

    // back-to-back: instr_valid held high is accepted every third cycle
    instr = 32'h00221821;
    instr_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      check($sformatf("b2b.ready%0d", i), 32'(instr_ready), ((i % 3) == 0) ? 32'd1 : 32'd0);
      check($sformatf("b2b.valid%0d", i), 32'(res_valid), ((i % 3) == 2) ? 32'd1 : 32'd0);
      if ((i % 3) == 2) check($sformatf("b2b.data%0d", i), res_data, 32'd12);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
